exec_ctrl: RTL and testbench

Sequencer for the integer execute path. It accepts one raw 32-bit instruction through a valid/ready handshake and decodes it. It then reads operands from reg_file, drives alu, and writes the result back to reg_file. It sits between the instruction decoders and the register file/ALU pair, and processes one instruction every 4 cycles.

---
 rtl/exec_pkg.sv | 30 +++
 rtl/exec_decode.sv | 30 +++
 rtl/exec_ctrl.sv | 108 ++++++++++
 tb/tb_exec_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the integer execute sequencer
package exec_pkg;
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_AND = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_REM = 3'd7;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef struct packed {
    logic        legal;
    logic        is_imm;
    logic [2:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } dec_t;
endpackage

// File: rtl/exec_decode.sv
// exec_decode: raw RISC-V instruction to decoded struct (R/I-type integer subset)
module exec_decode import exec_pkg::*; (
  input  logic [31:0] instruction,
  output dec_t        dec
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  assign op = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  always_comb begin
    dec = '0;
    dec.rd = instruction[11:7];
    dec.rs1 = instruction[19:15];
    dec.rs2 = instruction[24:20];
    dec.imm = instruction[31:20];
    dec.is_imm = op == OP_I;
    if (op == OP_I || (op == OP_R && f7 == F7_BASE)) begin
      dec.legal = f3 inside {F3_ADD, F3_XOR, F3_OR, F3_AND};
      dec.alu_op = f3 == F3_ADD ? ALU_ADD : f3 == F3_XOR ? ALU_XOR : f3 == F3_OR ? ALU_OR : ALU_AND;
    end else if (op == OP_R && f7 == F7_SUB) begin
      dec.legal = f3 == F3_ADD;
      dec.alu_op = ALU_SUB;
    end else if (op == OP_R && f7 == F7_MUL) begin
      dec.legal = f3 inside {3'b000, 3'b100, 3'b110};
      dec.alu_op = f3 == 3'b000 ? ALU_MUL : f3 == 3'b100 ? ALU_DIV : ALU_REM;
    end
    if (!dec.legal) dec.alu_op = ALU_ADD;
  end
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: 4-cycle IDLE/READ/EXEC/WB sequencer driving reg_file and alu.
// Define EXEC_TRACE_EN to print one line per retired instruction.
module exec_ctrl import exec_pkg::*; #(
  parameter int XLEN = 64,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_val,
  input  logic [XLEN-1:0] rf_rs2_val,
  output logic            rf_write_sig,
  output logic [4:0]      rf_write_reg,
  output logic [XLEN-1:0] rf_write_val,
  output logic [OPW-1:0]  alu_opcode,
  output logic [XLEN-1:0] alu_value1,
  output logic [XLEN-1:0] alu_value2,
  input  logic [XLEN-1:0] alu_result,
  output logic            done,
  output logic            illegal
);
  state_t state_q, state_d;
  dec_t dec_w, dec_q, dec_d;
  logic [XLEN-1:0] b_q, b_d, byp_q, byp_d, imm_x;
  exec_decode u_dec (.instruction(instruction), .dec(dec_w));
  assign imm_x = {{(XLEN-12){dec_q.imm[11]}}, dec_q.imm};
  always_comb begin
    state_d = state_q;
    dec_d = dec_q;
    b_d = b_q;
    byp_d = byp_q;
    in_ready = state_q == IDLE;
    rf_rs1 = '0;
    rf_rs2 = '0;
    rf_write_sig = 1'b0;
    rf_write_reg = '0;
    rf_write_val = '0;
    alu_opcode = '0;
    alu_value1 = '0;
    alu_value2 = '0;
    done = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        dec_d = dec_w;
        state_d = READ;
      end
      READ: begin
        rf_rs1 = dec_q.legal ? dec_q.rs1 : '0;
        rf_rs2 = dec_q.legal ? dec_q.rs2 : '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (dec_q.legal) begin
          alu_opcode = OPW'(dec_q.alu_op);
          alu_value1 = rf_rs1_val;
          alu_value2 = dec_q.is_imm ? imm_x : rf_rs2_val;
        end
        b_d = alu_value2;
        // the alu stalls on a zero operand B, so that result is produced here instead
        byp_d = dec_q.alu_op inside {ALU_AND, ALU_MUL} ? '0 : dec_q.alu_op == ALU_DIV ? '1 : rf_rs1_val;
        state_d = WB;
      end
      WB: begin
        rf_write_reg = dec_q.rd;
        rf_write_sig = dec_q.legal && dec_q.rd != 5'd0;
        rf_write_val = b_q == '0 ? byp_q : alu_result;
        done = 1'b1;
        illegal = !dec_q.legal;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      dec_q <= '0;
      b_q <= '0;
      byp_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q <= dec_d;
      b_q <= b_d;
      byp_q <= byp_d;
    end
`ifdef EXEC_TRACE_EN
  function automatic string mnem(input logic [2:0] op);
    case (op)
      ALU_ADD: return "add";
      ALU_SUB: return "sub";
      ALU_MUL: return "mul";
      ALU_DIV: return "div";
      ALU_XOR: return "xor";
      ALU_AND: return "and";
      ALU_OR:  return "or";
      default: return "rem";
    endcase
  endfunction
  always_ff @(posedge clk)
    if (!reset && state_q == WB)
      $display("exec_ctrl: %s%s x%0d = %h%s", mnem(dec_q.alu_op), dec_q.is_imm ? "i" : "",
               dec_q.rd, rf_write_val, dec_q.legal ? "" : " illegal");
`endif
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: scoreboard bench for exec_ctrl with behavioural reg_file and stalling alu
module tb_exec_ctrl;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic [31:0] instruction = '0;
  logic [4:0] rf_rs1, rf_rs2, rf_write_reg;
  logic [63:0] rf_rs1_val = '0, rf_rs2_val = '0, rf_write_val, alu_value1, alu_value2, alu_result = '0;
  logic rf_write_sig, done, illegal;
  logic [7:0] alu_opcode;
  logic [63:0] regs [32] = '{default: 64'd0};
  logic poke = 1'b0;
  logic [4:0] poke_a = '0;
  logic [63:0] poke_v = '0;
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {logic w; logic [4:0] rd; logic [63:0] val; logic ill;} exp_t;
  exp_t exp_q[$];

  exec_ctrl #(.XLEN(64), .OPW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_write_sig(rf_write_sig), .rf_write_reg(rf_write_reg), .rf_write_val(rf_write_val),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_result(alu_result),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      8'd0: return a + b;
      8'd1: return a - b;
      8'd2: return a * b;
      8'd3: return 64'($signed(a) / $signed(b));
      8'd4: return a ^ b;
      8'd5: return a & b;
      8'd6: return a | b;
      8'd7: return 64'($signed(a) % $signed(b));
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    rf_rs1_val <= regs[rf_rs1];
    rf_rs2_val <= regs[rf_rs2];
    if (alu_value2 != 64'd0) alu_result <= alu_f(alu_opcode, alu_value1, alu_value2);
    if (poke) regs[poke_a] <= poke_v;
    else if (rf_write_sig) regs[rf_write_reg] <= rf_write_val;
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rf_write_sig && !done) begin
      miscompares++;
      $display("FAIL stray_write: rf_write_sig=1 while done=0 (reg %0d)", rf_write_reg);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_done: done=1 with no instruction pending");
      end else begin
        e = exp_q.pop_front();
        vectors += 3;
        if (rf_write_sig !== e.w) begin
          miscompares++;
          $display("FAIL write_sig: got %b expected %b", rf_write_sig, e.w);
        end
        if (e.w && (rf_write_reg !== e.rd || rf_write_val !== e.val)) begin
          miscompares++;
          $display("FAIL write_data: got x%0d=%h expected x%0d=%h", rf_write_reg, rf_write_val, e.rd, e.val);
        end
        if (illegal !== e.ill) begin
          miscompares++;
          $display("FAIL illegal: got %b expected %b", illegal, e.ill);
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: %0d instructions never retired", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [63:0] v);
    poke_a = a; poke_v = v; poke = 1'b1;
    tick();
    poke = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic w, input logic [4:0] rd, input logic [63:0] v, input logic ill);
    int n = 0;
    while (!in_ready && n < 12) begin tick(); n++; end
    instruction = ins; in_valid = 1'b1;
    exp_q.push_back('{w, rd, v, ill});
    tick();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors += 3;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if ({done, illegal, rf_write_sig, rf_rs1, rf_rs2, rf_write_reg} !== '0) begin
      miscompares++; $display("FAIL reset_ctrl_outs: got %b expected 0", {done, illegal, rf_write_sig, rf_rs1, rf_rs2, rf_write_reg});
    end
    if ({alu_opcode, alu_value1, alu_value2, rf_write_val} !== '0) begin
      miscompares++; $display("FAIL reset_data_outs: got nonzero alu/write data");
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_timing();
    set_reg(1, 64'd5); set_reg(2, 64'd7);
    tick();
    instruction = rtype(7'h00, 3'b000, 5'd3, 5'd1, 5'd2); in_valid = 1'b1;
    exp_q.push_back('{1'b1, 5'd3, 64'd12, 1'b0});
    tick();
    in_valid = 1'b0;
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_c1: got %b expected 0", in_ready); end
    if (rf_rs1 !== 5'd1 || rf_rs2 !== 5'd2) begin miscompares++; $display("FAIL read_addr: got %0d,%0d expected 1,2", rf_rs1, rf_rs2); end
    tick();
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_c2: got %b expected 0", in_ready); end
    if (alu_opcode !== 8'd0 || alu_value1 !== 64'd5 || alu_value2 !== 64'd7) begin
      miscompares++; $display("FAIL exec_drive: got op=%0d a=%0d b=%0d expected op=0 a=5 b=7", alu_opcode, alu_value1, alu_value2);
    end
    tick();
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_c3: got %b expected 0", in_ready); end
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL done_c3: %0d pending, expected retire in cycle 3", exp_q.size()); end
    tick();
    vectors += 2;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_c4: got %b expected 1", in_ready); end
    if (regs[3] !== 64'd12) begin miscompares++; $display("FAIL x3_written: got %0d expected 12", regs[3]); end
    drain();
  endtask

  task automatic test_imm();
    set_reg(1, 64'd10);
    issue(itype(12'hFFD, 3'b000, 5'd4, 5'd1), 1'b1, 5'd4, 64'd7, 1'b0);
    issue(itype(12'hFFF, 3'b100, 5'd5, 5'd1), 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0);
    issue(itype(12'h0F0, 3'b111, 5'd5, 5'd1), 1'b1, 5'd5, 64'd0, 1'b0);
  endtask

  task automatic test_zero_b();
    set_reg(1, 64'd9); set_reg(2, 64'd0);
    issue(rtype(7'h01, 3'b100, 5'd6, 5'd1, 5'd2), 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(rtype(7'h01, 3'b110, 5'd7, 5'd1, 5'd2), 1'b1, 5'd7, 64'd9, 1'b0);
    issue(rtype(7'h00, 3'b000, 5'd8, 5'd1, 5'd2), 1'b1, 5'd8, 64'd9, 1'b0);
    issue(rtype(7'h01, 3'b000, 5'd8, 5'd1, 5'd2), 1'b1, 5'd8, 64'd0, 1'b0);
  endtask

  task automatic test_x0_illegal();
    issue(rtype(7'h00, 3'b000, 5'd0, 5'd1, 5'd2), 1'b0, 5'd0, 64'd0, 1'b0);
    issue(rtype(7'h00, 3'b001, 5'd3, 5'd1, 5'd2), 1'b0, 5'd3, 64'd0, 1'b1);
    issue(32'h0000_0073, 1'b0, 5'd0, 64'd0, 1'b1);
    vectors++;
    if (regs[3] !== 64'd12) begin miscompares++; $display("FAIL x3_kept: got %0d expected 12", regs[3]); end
  endtask

  task automatic test_reset_mid();
    instruction = rtype(7'h01, 3'b000, 5'd9, 5'd1, 5'd2); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (alu_opcode !== 8'd2) begin miscompares++; $display("FAIL mul_exec_op: got %0d expected 2", alu_opcode); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors += 2;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
    if (done !== 1'b0) begin miscompares++; $display("FAIL done_after_reset: got %b expected 0", done); end
    tick(); tick(); tick();
    vectors++;
    if (regs[9] !== 64'd0) begin miscompares++; $display("FAIL x9_untouched: got %h expected 0", regs[9]); end
    issue(itype(12'h001, 3'b000, 5'd9, 5'd1), 1'b1, 5'd9, 64'd10, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [63:0] val [4];
    int last = 0, n;
    set_reg(1, 64'd3); set_reg(2, 64'd4);
    ins = '{rtype(7'h00, 3'b000, 5'd10, 5'd1, 5'd2), rtype(7'h20, 3'b000, 5'd11, 5'd1, 5'd2),
            rtype(7'h00, 3'b100, 5'd12, 5'd1, 5'd2), rtype(7'h01, 3'b000, 5'd13, 5'd1, 5'd2)};
    val = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd12};
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < 12) begin tick(); n++; end
      if (k > 0) begin
        vectors++;
        if (cyc - last !== 4) begin miscompares++; $display("FAIL accept_spacing: got %0d cycles expected 4", cyc - last); end
      end
      last = cyc;
      instruction = ins[k];
      exp_q.push_back('{1'b1, 5'(10 + k), val[k], 1'b0});
      tick();
    end
    in_valid = 1'b0;
    drain();
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_imm();
    test_zero_b();
    test_x0_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
